vga_layer_mixer: RTL and testbench
==================================

Name: vga_layer_mixer

Overview:
- Parametrised N-layer priority compositor for the VGA pixel pipeline.
- Takes the per-pixel RGB of each draw stage in parallel, plus one set of timing signals.
- Emits one composited, registered RGB stream with the timing signals delay-matched.
- Replaces the chained last-assignment RGB output register at the top level; adds frame-synchronous layer enables, blanking enforcement, a frame counter and optional 50% blending.

Parameters:
- LAYERS, 4: number of input layers; index LAYERS-1 has highest priority.
- COLOR_W, 12: RGB width per layer; must be a multiple of 3 (R,G,B each COLOR_W/3, R in MSBs).
- CNT_W, 11: hcount/vcount width.
- FCNT_W, 16: frame counter width.

Ports:
- pclk  in  1  pixel clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- layer_rgb  in  LAYERS*COLOR_W  layer i colour at bits [i*COLOR_W +: COLOR_W].
- layer_vld  in  LAYERS  bit i: layer i opaque at this pixel.
- layer_en  in  LAYERS  requested layer enables; sampled only at frame boundary.
- layer_blend  in  LAYERS  bit i: layer i blends 50% with the layer beneath. Used only with the optional feature.
- bg_rgb  in  COLOR_W  colour when no layer wins.
- hcount_in, vcount_in  in  CNT_W  pixel position.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1  timing.
- hcount_out, vcount_out  out  CNT_W  delayed position.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  delayed timing.
- rgb_out  out  COLOR_W  composited colour.
- frame_cnt  out  FCNT_W  count of vsync_in rising edges.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0.
  - Enable shadow register en_q = 0.
  - vsync edge-detect register = 0.
  - All pipeline registers = 0.
- Latency: fixed 2 pclk cycles for every output vs. the corresponding inputs.
  - Timing and count signals pass through 2 register stages unchanged.
  - No stalls; no handshake.
- Frame boundary:
  - Rising edge of vsync_in = vsync_in=1 and registered previous value 0.
  - On that clock edge, en_q <= layer_en and frame_cnt <= frame_cnt+1, wrapping at 2^FCNT_W.
  - Stage 1 uses the new en_q from the following cycle onward.
  - layer_en changes mid-frame have no effect until the next edge.
- Stage 1 (register):
  - Winner w = highest i with layer_vld[i] & en_q[i].
  - Register: hit flag, winner colour, below colour, winner blend flag, blank = hblnk_in|vblnk_in.
  - Below colour = next-highest valid & enabled layer under w; bg_rgb if none.
  - No winner: winner colour = bg_rgb, hit = 0.
- Stage 2 (register):
  - blank=1: rgb_out = 0, regardless of layers.
  - Otherwise rgb_out = winner colour, or blended colour when the optional feature applies.
- Simultaneous vsync edge and layer_vld on the same cycle: the pixel on that cycle uses the old en_q.
- LAYERS=1 is legal: below colour is always bg_rgb.
- Reset deasserted mid-frame: bg_rgb-only output (en_q=0) until the first vsync rising edge; frame_cnt starts from 0.

Optional Feature:
- Macro: VGA_LAYER_MIXER_BLEND_EN.
- Defined:
  - If hit, blend flag of w set, and not blank: each channel of rgb_out = (winner_ch + below_ch) >> 1.
  - Add in COLOR_W/3+1 bits, truncate (floor).
  - Blend computed in stage 2; latency stays 2.
- Undefined:
  - layer_blend is ignored and the blend datapath is not synthesised.
  - Output is always the opaque winner colour.

Test Plan:
- Reset and bg-only path:
  - Stimulus: hold rst=0 for 5 cycles, release, bg_rgb=12'h123, all layer_vld=1, no vsync edge.
  - Response: all outputs 0 during reset; afterwards rgb_out=12'h123 exactly 2 cycles after each active pixel, since en_q=0.
- Priority:
  - Stimulus: pulse vsync with layer_en=4'b1111; then layer_vld=4'b0101, layer0=12'hF00, layer2=12'h0F0.
  - Response: rgb_out=12'h0F0 two cycles later. With layer_vld=4'b0001 the response is 12'hF00.
- Frame-synchronous enable:
  - Stimulus: change layer_en to 4'b0001 mid-frame.
  - Response: output unchanged until the vsync rising edge; the pixel on the edge cycle still uses the old enables; later pixels use 4'b0001. frame_cnt increments by exactly 1 per edge.
- Blanking and delay match:
  - Stimulus: random layers with hblnk_in=1 for 160 cycles.
  - Response: rgb_out=0 for exactly those cycles shifted by 2; hcount_out/vcount_out/syncs equal inputs delayed by 2 cycles, every cycle.
- Blend (macro defined):
  - Stimulus: layer3=12'hF80, blend[3]=1, layer1=12'h084 valid, layer2 invalid.
  - Response: rgb_out=12'h782. With no lower layer and bg_rgb=12'h000 the response is 12'h740. With the macro undefined the response is 12'hF80.
- Wrap:
  - Stimulus: preload by driving 2^FCNT_W vsync pulses (FCNT_W=4 in the bench).
  - Response: frame_cnt returns to 0 after 16 edges.

Source files
------------

// File: rtl/vga_layer_mixer.sv
// N-layer priority compositor: registered RGB plus delay-matched timing; optional 50% blend under VGA_LAYER_MIXER_BLEND_EN.
// Latency is 2 pclk for every pipelined output; free-running, no backpressure or stalls.
module vga_layer_mixer #(
   parameter int LAYERS  = 4,
   parameter int COLOR_W = 12,
   parameter int CNT_W   = 11,
   parameter int FCNT_W  = 16
) (
   input  logic                        pclk,
   input  logic                        rst,
   input  logic [LAYERS*COLOR_W-1:0]   layer_rgb,
   input  logic [LAYERS-1:0]           layer_vld,
   input  logic [LAYERS-1:0]           layer_en,
   input  logic [LAYERS-1:0]           layer_blend,
   input  logic [COLOR_W-1:0]          bg_rgb,
   input  logic [CNT_W-1:0]            hcount_in,
   input  logic [CNT_W-1:0]            vcount_in,
   input  logic                        hsync_in,
   input  logic                        vsync_in,
   input  logic                        hblnk_in,
   input  logic                        vblnk_in,
   output logic [CNT_W-1:0]            hcount_out,
   output logic [CNT_W-1:0]            vcount_out,
   output logic                        hsync_out,
   output logic                        vsync_out,
   output logic                        hblnk_out,
   output logic                        vblnk_out,
   output logic [COLOR_W-1:0]          rgb_out,
   output logic [FCNT_W-1:0]           frame_cnt
);

   localparam int CH_W = COLOR_W / 3;

   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic [CNT_W-1:0] vcount;
      logic             hsync;
      logic             vsync;
      logic             hblnk;
      logic             vblnk;
   } tim_t;

   tim_t                tim1_d, tim1_q, tim2_q;
   logic [LAYERS-1:0]   en_d, en_q;
   logic                vs_prev_d, vs_prev_q;
   logic [FCNT_W-1:0]   fcnt_d, fcnt_q;
   logic                hit_d, hit_q;
   logic                blank_d, blank_q;
   logic [COLOR_W-1:0]  win_d, win_q;
   logic [COLOR_W-1:0]  below_d, below_q;
   logic                blend_d, blend_q;
   logic [COLOR_W-1:0]  rgb_d, rgb_q;
   logic [COLOR_W-1:0]  mix;
   logic                vs_rise;

   // Enables and frame count only move on a vsync rising edge, so a frame never changes its layer set midway.
   always_comb begin
      vs_rise   = vsync_in & ~vs_prev_q;
      vs_prev_d = vsync_in;
      en_d      = vs_rise ? layer_en : en_q;
      fcnt_d    = fcnt_q + FCNT_W'(vs_rise);
   end

   // Walking upward, each new visible layer pushes the previous winner down to "below".
   always_comb begin
      hit_d   = 1'b0;
      win_d   = bg_rgb;
      below_d = bg_rgb;
      blend_d = 1'b0;
      for (int i = 0; i < LAYERS; i++) begin
         if (layer_vld[i] && en_q[i]) begin
            below_d = win_d;
            win_d   = layer_rgb[i*COLOR_W +: COLOR_W];
            hit_d   = 1'b1;
`ifdef VGA_LAYER_MIXER_BLEND_EN
            blend_d = layer_blend[i];
`endif
         end
      end
      blank_d = hblnk_in | vblnk_in;
      tim1_d  = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                  vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};
   end

   always_comb begin
      mix = win_q;
`ifdef VGA_LAYER_MIXER_BLEND_EN
      for (int c = 0; c < 3; c++) begin
         logic [CH_W:0] sum;
         sum = {1'b0, win_q[c*CH_W +: CH_W]} + {1'b0, below_q[c*CH_W +: CH_W]};
         mix[c*CH_W +: CH_W] = sum[CH_W:1];
      end
`endif
      if (blank_q)
         rgb_d = '0;
      else if (hit_q && blend_q)
         rgb_d = mix;
      else
         rgb_d = win_q;
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         en_q      <= '0;
         vs_prev_q <= 1'b0;
         fcnt_q    <= '0;
         hit_q     <= 1'b0;
         blank_q   <= 1'b0;
         win_q     <= '0;
         below_q   <= '0;
         blend_q   <= 1'b0;
         tim1_q    <= '0;
         tim2_q    <= '0;
         rgb_q     <= '0;
      end else begin
         en_q      <= en_d;
         vs_prev_q <= vs_prev_d;
         fcnt_q    <= fcnt_d;
         hit_q     <= hit_d;
         blank_q   <= blank_d;
         win_q     <= win_d;
         below_q   <= below_d;
         blend_q   <= blend_d;
         tim1_q    <= tim1_d;
         tim2_q    <= tim1_q;
         rgb_q     <= rgb_d;
      end
   end

   logic unused_ok;
   assign unused_ok = ^{layer_blend, below_q, mix};

   assign hcount_out = tim2_q.hcount;
   assign vcount_out = tim2_q.vcount;
   assign hsync_out  = tim2_q.hsync;
   assign vsync_out  = tim2_q.vsync;
   assign hblnk_out  = tim2_q.hblnk;
   assign vblnk_out  = tim2_q.vblnk;
   assign rgb_out    = rgb_q;
   assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Randomised and directed bench for vga_layer_mixer against a list-based compositing model.
module tb_vga_layer_mixer;

   logic              pclk = 1'b0;
   logic              rst;
   logic [47:0]       layer_rgb;
   logic [3:0]        layer_vld, layer_en, layer_blend;
   logic [11:0]       bg_rgb;
   logic [10:0]       hcount_in, vcount_in, hcount_out, vcount_out;
   logic              hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic              hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0]       rgb_out;
   logic [3:0]        frame_cnt;

   vga_layer_mixer #(.LAYERS(4), .COLOR_W(12), .CNT_W(11), .FCNT_W(4)) dut (
      .pclk(pclk), .rst(rst), .layer_rgb(layer_rgb), .layer_vld(layer_vld),
      .layer_en(layer_en), .layer_blend(layer_blend), .bg_rgb(bg_rgb),
      .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in),
      .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
      .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .frame_cnt(frame_cnt)
   );

   always #5 pclk = ~pclk;

   typedef struct packed {
      logic [11:0] rgb;
      logic [10:0] hc;
      logic [10:0] vc;
      logic        hs, vs, hb, vb;
   } exp_t;

   exp_t        exp_q[$];
   logic [3:0]  en_m;
   logic        prev_m;
   int          fcnt_m;
   int          n_checks = 0;
   int          n_err = 0;
   logic [10:0] hc_r = '0;
   logic        vs_r = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // Model: list the visible layers bottom-up; the top entry wins, the one under it is "below".
   task automatic model_push();
      int          vis[$];
      exp_t        e;
      logic [11:0] wc, bc;
      for (int i = 0; i < 4; i++)
         if (layer_vld[i] && en_m[i]) vis.push_back(i);
      wc = (vis.size() > 0) ? layer_rgb[vis[vis.size()-1]*12 +: 12] : bg_rgb;
      bc = (vis.size() > 1) ? layer_rgb[vis[vis.size()-2]*12 +: 12] : bg_rgb;
      e.rgb = wc;
`ifdef VGA_LAYER_MIXER_BLEND_EN
      if (vis.size() > 0 && layer_blend[vis[vis.size()-1]]) begin
         int r, g, b;
         r = (int'(wc[11:8]) + int'(bc[11:8])) / 2;
         g = (int'(wc[7:4])  + int'(bc[7:4]))  / 2;
         b = (int'(wc[3:0])  + int'(bc[3:0]))  / 2;
         e.rgb = {4'(r), 4'(g), 4'(b)};
      end
`endif
      if (hblnk_in || vblnk_in) e.rgb = '0;
      e.hc = hcount_in; e.vc = vcount_in;
      e.hs = hsync_in;  e.vs = vsync_in; e.hb = hblnk_in; e.vb = vblnk_in;
      exp_q.push_back(e);
      if (vsync_in && !prev_m) begin
         en_m   = layer_en;
         fcnt_m = (fcnt_m + 1) % 16;
      end
      prev_m = vsync_in;
   endtask

   task automatic check_out();
      exp_t e;
      e = exp_q.pop_front();
      check("rgb",    32'(rgb_out),    32'(e.rgb));
      check("hcount", 32'(hcount_out), 32'(e.hc));
      check("vcount", 32'(vcount_out), 32'(e.vc));
      check("sync",   32'({hsync_out, vsync_out}), 32'({e.hs, e.vs}));
      check("blnk",   32'({hblnk_out, vblnk_out}), 32'({e.hb, e.vb}));
      check("fcnt",   32'(frame_cnt),  32'(fcnt_m));
   endtask

   task automatic drive(input logic [3:0] vld, input logic [3:0] en, input logic [3:0] bl,
                        input logic [47:0] rgb, input logic [11:0] bg,
                        input logic hb, input logic vb, input logic vs, input logic hs);
      @(negedge pclk);
      check_out();
      hc_r        = hc_r + 11'd1;
      layer_vld   = vld;  layer_en = en; layer_blend = bl;
      layer_rgb   = rgb;  bg_rgb   = bg;
      hblnk_in    = hb;   vblnk_in = vb; vsync_in = vs; hsync_in = hs;
      hcount_in   = hc_r; vcount_in = 11'($urandom);
      model_push();
   endtask

   task automatic do_reset(input int cycles);
      @(negedge pclk);
      rst = 1'b0;
      layer_vld = 4'hF; layer_en = 4'hF; layer_blend = 4'h0;
      layer_rgb = {$urandom, $urandom}; bg_rgb = 12'h123;
      hcount_in = '0; vcount_in = '0;
      hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
      vs_r = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge pclk);
         check("rst_rgb", 32'(rgb_out), 32'h0);
         check("rst_tim", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
         check("rst_fcnt", 32'(frame_cnt), 32'h0);
      end
      rst = 1'b1;
      exp_q.delete();
      exp_q.push_back('0);
      en_m = '0; prev_m = 1'b0; fcnt_m = 0;
      model_push();
   endtask

   task automatic rnd_cycle(input logic force_hb);
      logic hb, vb;
      if ($urandom_range(0, 39) == 0) vs_r = ~vs_r;
      hb = force_hb | ($urandom_range(0, 3) == 0);
      vb = ($urandom_range(0, 7) == 0);
      drive(4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom},
            12'($urandom), hb, vb, vs_r, 1'($urandom));
   endtask

   logic [47:0] rgbp, rgbb;
   int          f_before;

   initial begin
      rst = 1'b0;
      do_reset(5);
      repeat (6) drive(4'hF, 4'hF, 4'h0, {$urandom, $urandom}, 12'h123, 0, 0, 0, 0);
      check("bg_only", 32'(rgb_out), 32'h123);

      rgbp = {12'h000, 12'h0F0, 12'h000, 12'hF00};
      drive(4'h0, 4'hF, 4'h0, rgbp, 12'h123, 0, 0, 1, 0);
      drive(4'h0, 4'hF, 4'h0, rgbp, 12'h123, 0, 0, 0, 0);
      repeat (3) drive(4'b0101, 4'hF, 4'h0, rgbp, 12'h123, 0, 0, 0, 0);
      check("prio_l2", 32'(rgb_out), 32'h0F0);
      repeat (3) drive(4'b0001, 4'hF, 4'h0, rgbp, 12'h123, 0, 0, 0, 0);
      check("prio_l0", 32'(rgb_out), 32'hF00);

      repeat (3) drive(4'b0101, 4'b0001, 4'h0, rgbp, 12'h123, 0, 0, 0, 0);
      check("en_hold", 32'(rgb_out), 32'h0F0);
      f_before = fcnt_m;
      repeat (3) drive(4'b0101, 4'b0001, 4'h0, rgbp, 12'h123, 0, 0, 1, 0);
      check("en_edge_pix", 32'(rgb_out), 32'h0F0);
      check("fcnt_step", 32'(frame_cnt), 32'((f_before + 1) % 16));
      drive(4'b0101, 4'b0001, 4'h0, rgbp, 12'h123, 0, 0, 0, 0);
      check("en_new", 32'(rgb_out), 32'hF00);

      repeat (160) rnd_cycle(1'b1);
      repeat (300) rnd_cycle(1'b0);

      rgbb = {12'hF80, 12'h000, 12'h084, 12'h000};
      drive(4'h0, 4'hF, 4'h0, rgbb, 12'h123, 0, 0, 0, 0);
      drive(4'h0, 4'hF, 4'h0, rgbb, 12'h123, 0, 0, 1, 0);
      drive(4'h0, 4'hF, 4'h0, rgbb, 12'h123, 0, 0, 0, 0);
      repeat (3) drive(4'b1010, 4'hF, 4'b1000, rgbb, 12'h123, 0, 0, 0, 0);
`ifdef VGA_LAYER_MIXER_BLEND_EN
      check("blend_mix", 32'(rgb_out), 32'h782);
`else
      check("blend_mix", 32'(rgb_out), 32'hF80);
`endif
      repeat (3) drive(4'b1000, 4'hF, 4'b1000, rgbb, 12'h000, 0, 0, 0, 0);
`ifdef VGA_LAYER_MIXER_BLEND_EN
      check("blend_bg", 32'(rgb_out), 32'h740);
`else
      check("blend_bg", 32'(rgb_out), 32'hF80);
`endif

      do_reset(3);
      repeat (15) begin
         drive(4'h0, 4'hF, 4'h0, rgbb, 12'h123, 0, 0, 1, 0);
         drive(4'h0, 4'hF, 4'h0, rgbb, 12'h123, 0, 0, 0, 0);
      end
      check("pre_wrap", 32'(frame_cnt), 32'd15);
      drive(4'h0, 4'hF, 4'h0, rgbb, 12'h123, 0, 0, 1, 0);
      drive(4'h0, 4'hF, 4'h0, rgbb, 12'h123, 0, 0, 0, 0);
      check("wrap", 32'(frame_cnt), 32'd0);
      repeat (3) drive(4'h0, 4'hF, 4'h0, rgbb, 12'h123, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
